pipeline_exec_ctrl: RTL

//  Run controller for the 5-stage pipeline. Drives the shared i_pipeline_enable of IF/ID, ID/EX, EX/MEM and MEM/WB.

---
 rtl/pipeline_exec_ctrl.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/pipeline_exec_ctrl.sv
// pipeline_exec_ctrl
//   Run controller for the 5-stage pipeline. It produces the single shared
//   enable for the IF/ID, ID/EX, EX/MEM and MEM/WB latches.
//
//   The pipeline runs in one of two modes:
//     - Continuous: it stops when the halt flag leaves MEM/WB, or when the
//       cycle budget is used up.
//     - Single-step: each rising edge of the step request advances the
//       pipeline by exactly one cycle.
//
//   A saturating counter records every enabled cycle.
//
// Parameters
//   NB_CNT      width of the enabled-cycle counter
//   MAX_CYCLES  cycle budget in RUN. The run halts with o_timeout set instead
//               of letting the counter reach this value.
//
// Ports
//   i_clock            clock, all state changes on the rising edge
//   i_reset            synchronous reset, active low, highest priority
//   i_start            leave IDLE (only looked at in IDLE)
//   i_step_mode        1 = single-step, 0 = continuous (sampled with i_start)
//   i_step_req         step request, each rising edge is one advance
//   i_clear            abort / acknowledge, back to IDLE with counter cleared
//   i_halt             halt flag coming out of MEM/WB
//   o_pipeline_enable  registered enable to all pipeline latches
//   o_state            0 IDLE, 1 RUN, 2 STEP, 3 HALTED
//   o_halted           1 while in HALTED
//   o_timeout          1 in HALTED when the budget ran out
//   o_step_done        one-cycle pulse after each step enable pulse
//   o_cycle_count      enabled cycles since the last clear, saturating
module pipeline_exec_ctrl #(
  parameter int                 NB_CNT     = 32,
  parameter logic [NB_CNT-1:0]  MAX_CYCLES = NB_CNT'(32'hFFFF)
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic              i_step_mode,
  input  logic              i_step_req,
  input  logic              i_clear,
  input  logic              i_halt,
  output logic              o_pipeline_enable,
  output logic [1:0]        o_state,
  output logic              o_halted,
  output logic              o_timeout,
  output logic              o_step_done,
  output logic [NB_CNT-1:0] o_cycle_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    STEP   = 2'd2,
    HALTED = 2'd3
  } state_t;

  localparam logic [NB_CNT-1:0] CNT_ONE     = {{(NB_CNT-1){1'b0}}, 1'b1};
  // The run is stopped one enabled cycle early, so the counter never
  // reaches the budget itself.
  localparam logic [NB_CNT-1:0] BUDGET_LAST = MAX_CYCLES - CNT_ONE;

  state_t            state_q, state_d;
  logic              enable_q, enable_d;
  logic              timeout_q, timeout_d;
  logic              step_done_q, step_done_d;
  logic              step_req_q;
  logic [NB_CNT-1:0] count_q, count_d, count_inc;
  logic              step_rise;
  logic              budget_hit;

  // Saturating increment of the counter.
  // budget_hit fires on the edge where granting one more enabled cycle would
  // make the counter reach MAX_CYCLES.
  always_comb begin
    count_inc  = (count_q == '1) ? count_q : count_q + CNT_ONE;
    budget_hit = enable_q && (count_inc >= BUDGET_LAST);
    step_rise  = i_step_req && !step_req_q;
  end

  // State and output registers.
  // The previous step request is tracked in every state, so a request that
  // is already high when STEP is entered does not count as a rise.
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      state_q     <= IDLE;
      enable_q    <= 1'b0;
      timeout_q   <= 1'b0;
      step_done_q <= 1'b0;
      step_req_q  <= 1'b0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      enable_q    <= enable_d;
      timeout_q   <= timeout_d;
      step_done_q <= step_done_d;
      step_req_q  <= i_step_req;
      count_q     <= count_d;
    end
  end

  // Next-state logic.
  // Clear overrides everything except reset. In RUN the halt flag and the
  // budget both lead to HALTED. In STEP only a halt seen during the enable
  // pulse counts, because a frozen pipeline presents a stale flag.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (i_start) state_d = i_step_mode ? STEP : RUN;
      RUN:     if (i_halt || budget_hit) state_d = HALTED;
      STEP:    if (enable_q && i_halt) state_d = HALTED;
      HALTED:  state_d = HALTED;
      default: state_d = IDLE;
    endcase
    if (i_clear) state_d = IDLE;
  end

  // Next values of the registered outputs.
  // - A halt takes priority over a timeout on the same edge, so o_timeout
  //   stays 0 in that case.
  // - A step pulse is only granted while the enable is low.
  // - o_step_done simply follows the step enable one cycle later.
  always_comb begin
    enable_d    = 1'b0;
    timeout_d   = timeout_q;
    step_done_d = 1'b0;
    count_d     = enable_q ? count_inc : count_q;
    case (state_q)
      IDLE: enable_d = i_start && !i_step_mode;
      RUN: begin
        if (i_halt) begin
          timeout_d = 1'b0;
        end else if (budget_hit) begin
          timeout_d = 1'b1;
        end else begin
          enable_d = 1'b1;
        end
      end
      STEP: begin
        enable_d    = !enable_q && step_rise;
        step_done_d = enable_q;
      end
      default: enable_d = 1'b0;
    endcase
    if (i_clear) begin
      enable_d    = 1'b0;
      timeout_d   = 1'b0;
      step_done_d = 1'b0;
      count_d     = '0;
    end
  end

  assign o_pipeline_enable = enable_q;
  assign o_state           = state_q;
  assign o_halted          = (state_q == HALTED);
  assign o_timeout         = timeout_q;
  assign o_step_done       = step_done_q;
  assign o_cycle_count     = count_q;

endmodule
